// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared opcodes, state encodings and select encodings for the MIPS-C controller
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_LINK  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // One-hot instruction class; all-zero means nop (unknown op or funct).
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/funct to one-hot instruction class
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  // Anything not recognised leaves every class bit clear and runs as a nop.
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle main controller: FSM, PC register and link register
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic        zero,
  input  logic [31:0] rs_val,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] link,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [2:0]  alu_op,
  output logic        mem_re,
  output logic        mem_we,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] link_q;
  iclass_t     cls_q;
  iclass_t     dec;
  logic        ir_we_c, reg_we_c, mem_re_c, mem_we_c;
  logic [31:0] j_target;
  logic [31:0] br_target;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (dec)
  );

  // pc_q already holds PC+4 whenever these targets are used.
  assign j_target  = {pc_q[31:28], addr26, 2'b00};
  assign br_target = pc_q + {{14{imm16[15]}}, imm16, 2'b00};

  // State, PC and per-instruction latches; link is captured in DECODE before any jump moves pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_RESET;
      cls_q   <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == ST_DECODE) begin
        cls_q  <= dec;
        link_q <= pc_q;
      end
    end
  end

  // Next state, PC update, strobes and writeback selects.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_we_c  = 1'b0;
    reg_we_c = 1'b0;
    mem_re_c = 1'b0;
    mem_we_c = 1'b0;
    reg_dst  = RD_RT;
    wd_sel   = WD_ALU;
    case (state_q)
      ST_FETCH: begin
        ir_we_c = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec.j) begin
          pc_d    = j_target;
          state_d = ST_FETCH;
        end else if (dec.jr) begin
          pc_d    = rs_val;
          state_d = ST_FETCH;
        end else if (dec.jal) begin
          pc_d    = j_target;
          state_d = ST_WB;
        end else if (dec == '0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q.lw || cls_q.sw) begin
          state_d = ST_MEM;
        end else if (cls_q.beq) begin
          if (zero) pc_d = br_target;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_re_c = cls_q.lw;
        mem_we_c = cls_q.sw;
        if (mem_ready) state_d = cls_q.lw ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_we_c = 1'b1;
        if (cls_q.jal) begin
          reg_dst = RD_RA;
          wd_sel  = WD_LINK;
        end else if (cls_q.addu || cls_q.subu) begin
          reg_dst = RD_RD;
        end else if (cls_q.lw) begin
          wd_sel  = WD_MEM;
        end
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // ALU controls stay asserted from EXEC through WB so the ALU result remains stable.
  always_comb begin
    alu_src = 1'b0;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      if (cls_q.subu || cls_q.beq) alu_op = ALU_SUB;
      if (cls_q.ori) begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end
      if (cls_q.lui) begin
        alu_src = 1'b1;
        ext_op  = EXT_LUI;
        alu_op  = ALU_OR;
      end
      if (cls_q.lw || cls_q.sw) begin
        alu_src = 1'b1;
        ext_op  = EXT_SIGN;
      end
    end
  end

  // Reset is synchronous, so strobes are masked directly to keep the reset cycle write-free.
  assign ir_we  = ir_we_c  & ~reset;
  assign reg_we = reg_we_c & ~reset;
  assign mem_re = mem_re_c & ~reset;
  assign mem_we = mem_we_c & ~reset;
  assign pc     = pc_q;
  assign link   = link_q;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against an instruction-level reference model
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam logic [31:0] PC_RST = 32'h0000_3000;

  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;
  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_JR = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] addr26 = '0;
  logic        zero = 1'b0;
  logic [31:0] rs_val = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc, link;
  logic        ir_we, reg_we, alu_src, mem_re, mem_we;
  logic [1:0]  reg_dst, wd_sel, ext_op;
  logic [2:0]  alu_op, state;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_pc;

  mc_ctrl #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .imm16(imm16), .addr26(addr26),
    .zero(zero), .rs_val(rs_val), .mem_ready(mem_ready), .pc(pc), .link(link),
    .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .ext_op(ext_op), .alu_op(alu_op), .mem_re(mem_re), .mem_we(mem_we), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:   return (f == 6'h21) ? K_ADDU : (f == 6'h23) ? K_SUBU : (f == 6'h08) ? K_JR : K_NOP;
      6'h0d:   return K_ORI;
      6'h0f:   return K_LUI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  // Runs one instruction from FETCH, checking every cycle against the instruction's documented behaviour.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [15:0] im,
                           input logic [25:0] ad, input logic z, input logic [31:0] rv,
                           input int waits, input bit abort);
    int k;
    int ph[$];
    int mi;
    logic [31:0] pc0, tgt, nxt, exp_pc;
    logic [2:0] e_alu;
    logic [1:0] e_ext, e_dst, e_wd;
    logic e_src;
    k = kind_of(o, f);
    op = o; funct = f; imm16 = im; addr26 = ad; zero = z; rs_val = rv;
    pc0 = m_pc;
    tgt = {pc0[31:28] + 4'd0, ad, 2'b00};
    tgt[31:28] = (pc0 + 32'd4) >> 28;
    ph.push_back(P_F);
    ph.push_back(P_D);
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ}) ph.push_back(P_E);
    if (k inside {K_LW, K_SW}) for (int i = 0; i <= waits; i++) ph.push_back(P_M);
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL}) ph.push_back(P_W);
    case (k)
      K_J, K_JAL: nxt = tgt;
      K_JR:       nxt = rv;
      K_BEQ:      nxt = z ? pc0 + 32'd4 + (32'(signed'(im)) * 4) : pc0 + 32'd4;
      default:    nxt = pc0 + 32'd4;
    endcase
    e_src = (k inside {K_ORI, K_LUI, K_LW, K_SW});
    e_ext = (k == K_LUI) ? 2'd2 : (k inside {K_LW, K_SW}) ? 2'd1 : 2'd0;
    e_alu = (k inside {K_SUBU, K_BEQ}) ? 3'd1 : (k inside {K_ORI, K_LUI}) ? 3'd2 : 3'd0;
    e_dst = (k == K_JAL) ? 2'd2 : (k inside {K_ADDU, K_SUBU}) ? 2'd1 : 2'd0;
    e_wd  = (k == K_JAL) ? 2'd2 : (k == K_LW) ? 2'd1 : 2'd0;
    mi = 0;
    foreach (ph[i]) begin
      int p;
      p = ph[i];
      if (p == P_M) begin
        mem_ready = (mi == waits);
        mi++;
      end else begin
        mem_ready = 1'($urandom);
      end
      if (abort && p == P_M) begin
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        step();
        reset = 1'b0;
        check("rst_state", 32'(state), 32'(ST_FETCH));
        check("rst_pc", pc, PC_RST);
        m_pc = PC_RST;
        return;
      end
      #1;
      exp_pc = (p == P_F) ? pc0 : (p == P_W && k == K_JAL) ? tgt : pc0 + 32'd4;
      case (p)
        P_F:     check("state_F", 32'(state), 32'(ST_FETCH));
        P_D:     check("state_D", 32'(state), 32'(ST_DECODE));
        P_E:     check("state_E", 32'(state), 32'(ST_EXEC));
        P_M:     check("state_M", 32'(state), 32'(ST_MEM));
        default: check("state_W", 32'(state), 32'(ST_WB));
      endcase
      check("pc", pc, exp_pc);
      check("ir_we", 32'(ir_we), 32'(p == P_F));
      check("reg_we", 32'(reg_we), 32'(p == P_W));
      check("mem_re", 32'(mem_re), 32'(p == P_M && k == K_LW));
      check("mem_we", 32'(mem_we), 32'(p == P_M && k == K_SW));
      if (p == P_E) begin
        check("alu_src", 32'(alu_src), 32'(e_src));
        check("ext_op", 32'(ext_op), 32'(e_ext));
        check("alu_op", 32'(alu_op), 32'(e_alu));
      end
      if (p == P_W) begin
        check("reg_dst", 32'(reg_dst), 32'(e_dst));
        check("wd_sel", 32'(wd_sel), 32'(e_wd));
        if (k == K_JAL) check("link", link, pc0 + 32'd4);
      end
      step();
    end
    m_pc = nxt;
    check("next_state", 32'(state), 32'(ST_FETCH));
    check("next_pc", pc, m_pc);
  endtask

  logic [5:0] op_tab [12];
  logic [5:0] fn_tab [12];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3e};
    fn_tab = '{6'h21, 6'h23, 6'h08, 6'h3f, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    reset = 1'b1;
    op = 6'h0d; imm16 = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_pc", pc, PC_RST);
      check("reset_state", 32'(state), 32'(ST_FETCH));
      check("reset_strobes", {28'd0, ir_we, reg_we, mem_re, mem_we}, 32'd0);
      step();
    end
    reset = 1'b0;
    m_pc = PC_RST;

    run_instr(6'h0d, 6'h00, 16'h1234, 26'h0001234, 1'b0, 32'h0, 0, 1'b0);
    run_instr(6'h23, 6'h00, 16'h0010, 26'h0000010, 1'b0, 32'h0, 3, 1'b0);
    run_instr(6'h02, 6'h00, 16'h0000, 26'h0000C04, 1'b0, 32'h0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 16'hFFFF, 26'h000FFFF, 1'b1, 32'h0, 0, 1'b0);
    check("beq_taken_pc", pc, 32'h0000_3010);
    run_instr(6'h04, 6'h00, 16'hFFFF, 26'h000FFFF, 1'b0, 32'h0, 0, 1'b0);
    check("beq_fall_pc", pc, 32'h0000_3014);
    run_instr(6'h02, 6'h00, 16'h0000, 26'h0000C08, 1'b0, 32'h0, 0, 1'b0);
    run_instr(6'h03, 6'h00, 16'h0C40, 26'h0000C40, 1'b0, 32'h0, 0, 1'b0);
    check("jal_pc", pc, 32'h0000_3100);
    run_instr(6'h00, 6'h08, 16'h0008, 26'h0000008, 1'b0, 32'h0000_3008, 0, 1'b0);
    check("jr_pc", pc, 32'h0000_3008);
    run_instr(6'h2b, 6'h00, 16'h0004, 26'h0000004, 1'b0, 32'h0, 2, 1'b1);
    run_instr(6'h3e, 6'h00, 16'h0000, 26'h0000000, 1'b0, 32'h0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 11);
      run_instr(op_tab[sel], fn_tab[sel], 16'($urandom), 26'($urandom), 1'($urandom),
                $urandom, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
